otf_quotient_converter: RTL and testbench
=========================================

OTF_QUOTIENT_CONVERTER -- requirements
Module: otf_quotient_converter

Interface
REQ-001 Parameter: N_DIGITS, default 32, number of quotient digits per division (range 2..64).
REQ-002 Parameter: CW, default $clog2(N_DIGITS+1), digit-count width.
REQ-003 Port: clk  input  1  single clock, all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse that begins a new conversion.
REQ-006 Port: digit_valid  input  1  q_value carries a new quotient digit this cycle.
REQ-007 Port: q_value  input  2  signed digit: 2'b01=+1, 2'b00=0, 2'b11=-1, 2'b10=illegal.
REQ-008 Port: error_flag  input  1  one-cycle retract request from the computation controller; discards the last accepted digit.
REQ-009 Port: digit_ready  output  1  converter can accept a digit this cycle.
REQ-010 Port: quotient  output  N_DIGITS+1  two's-complement value of the accepted digits (register Q).
REQ-011 Port: digit_count  output  CW  number of digits currently held.
REQ-012 Port: done  output  1  all N_DIGITS digits held; quotient final.
REQ-013 Port: invalid_digit  output  1  sticky; an illegal digit was accepted since the last start.

Function
REQ-014 States SHALL be IDLE, CONVERT, DONE; digit_ready = (state==CONVERT).
REQ-015 start in any state SHALL, next edge: state=CONVERT, Q=0, QM=all ones, digit_count=0, done=0, invalid_digit=0, snapshot invalidated; start overrides digit_valid and error_flag in the same cycle.
REQ-016 Accept = digit_valid & digit_ready & ~error_flag & ~start; unaccepted digits are dropped, never queued.
REQ-017 On accept, snapshot (Q,QM) is saved, then: +1: Q=Q<<1|1, QM=Q<<1|0; 0: Q=Q<<1|0, QM=QM<<1|1; -1: Q=QM<<1|1, QM=QM<<1|0; shifts truncate to N_DIGITS+1 bits.
REQ-018 An illegal digit SHALL be converted as 0 and set invalid_digit.
REQ-019 quotient and digit_count SHALL update on the edge following acceptance (latency 1 cycle); no combinational path from q_value to quotient.
REQ-020 When the accept brings digit_count to N_DIGITS, state SHALL become DONE and done=1 on that same edge; done holds until start, error_flag or rst.
REQ-021 error_flag in CONVERT or DONE with a valid snapshot SHALL restore (Q,QM), decrement digit_count, invalidate the snapshot, and force state=CONVERT, done=0.
REQ-022 error_flag with no valid snapshot (count 0, or second retract without an intervening accept) SHALL be ignored.
REQ-023 error_flag in IDLE SHALL be ignored; invalid_digit is not cleared by retraction.

Reset
REQ-024 rst SHALL asynchronously force state=IDLE, Q=0, QM=all ones, digit_count=0, done=0, invalid_digit=0, snapshot invalid; digit_ready=0.
REQ-025 rst asserted mid-conversion SHALL discard all digits; a start is required before further digits are accepted.

Structure
REQ-026 Shared package SHALL hold the digit encodings (DIGIT_POS, DIGIT_ZERO, DIGIT_NEG, DIGIT_ILL) and the state encoding, shared with computation_control.
REQ-027 One combinational sub-module, otf_step, SHALL compute next (Q,QM) from current (Q,QM) and digit; the top holds state, counter and snapshot.

Verification (N_DIGITS=4)
REQ-028 start; digits +1,0,-1,+1 -> quotient=5'b00111 (7), digit_count=4, done=1 one edge after 4th accept.
REQ-029 start; digits -1,-1,-1,-1 -> quotient=5'b10001 (-15), done=1.
REQ-030 start; +1,+1, error_flag, -1,0,+1 -> counts 1,2,1,2,3,4; final quotient=5'b00101 (5); second consecutive error_flag after the first leaves state unchanged.
REQ-031 start with digit_valid=1,q=+1 same cycle -> digit dropped, count=0; digit 2'b10 accepted -> converted as 0, invalid_digit=1 until next start.
REQ-032 rst pulsed after 2 digits -> quotient=0, count=0, digit_ready=0 immediately; digits ignored until start.
REQ-033 After done, error_flag -> done=0, count=3, quotient = 3-digit value; next digit re-completes with done=1.

Source files
------------

// File: rtl/otf_quotient_converter_pkg.sv
// Shared encodings for the on-the-fly quotient converter and the computation controller.
// Signed-digit codes on q_value and the converter state encoding.
package otf_quotient_converter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [1:0] DIGIT_POS  = 2'b01;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;
    localparam logic [1:0] DIGIT_NEG  = 2'b11;
    localparam logic [1:0] DIGIT_ILL  = 2'b10;

endpackage

// File: rtl/otf_quotient_converter_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the (Q, QM) register pair.
// QM always tracks Q minus one LSB, so a -1 digit never needs a borrow chain.
module otf_step
    import otf_quotient_converter_pkg::*;
#(
    parameter int W = 33
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next,
    output logic         illegal
);

    always_comb begin
        q_next  = q << 1;
        qm_next = (qm << 1) | W'(1);
        illegal = 1'b0;
        case (digit)
            DIGIT_POS: begin
                q_next  = (q << 1) | W'(1);
                qm_next = q << 1;
            end
            DIGIT_NEG: begin
                q_next  = (qm << 1) | W'(1);
                qm_next = qm << 1;
            end
            // An illegal code is folded into the zero digit and flagged.
            DIGIT_ILL: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/otf_quotient_converter.sv
// On-the-fly signed-digit to two's-complement quotient converter with single-digit retract.
// Holds the state machine, digit counter and the one-deep (Q, QM) snapshot used by error_flag.
module otf_quotient_converter
    import otf_quotient_converter_pkg::*;
#(
    parameter int N_DIGITS = 32,
    parameter int CW       = $clog2(N_DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                digit_valid,
    input  logic [1:0]          q_value,
    input  logic                error_flag,
    output logic                digit_ready,
    output logic [N_DIGITS:0]   quotient,
    output logic [CW-1:0]       digit_count,
    output logic                done,
    output logic                invalid_digit
);

    localparam int W = N_DIGITS + 1;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d, qm_q, qm_d;
    logic [W-1:0]   snap_q_q, snap_q_d, snap_qm_q, snap_qm_d;
    logic           snap_valid_q, snap_valid_d;
    logic [CW-1:0]  count_q, count_d;
    logic           invalid_q, invalid_d;

    logic [W-1:0]   step_q, step_qm;
    logic           step_illegal;
    logic           accept;

    otf_step #(.W(W)) u_step (
        .q       (q_q),
        .qm      (qm_q),
        .digit   (q_value),
        .q_next  (step_q),
        .qm_next (step_qm),
        .illegal (step_illegal)
    );

    assign digit_ready   = (state_q == CONVERT);
    assign accept        = digit_valid & digit_ready & ~error_flag & ~start;
    assign quotient      = q_q;
    assign digit_count   = count_q;
    assign done          = (state_q == DONE);
    assign invalid_digit = invalid_q;

    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        qm_d         = qm_q;
        snap_q_d     = snap_q_q;
        snap_qm_d    = snap_qm_q;
        snap_valid_d = snap_valid_q;
        count_d      = count_q;
        invalid_d    = invalid_q;

        if (start) begin
            state_d      = CONVERT;
            q_d          = '0;
            qm_d         = '1;
            snap_valid_d = 1'b0;
            count_d      = '0;
            invalid_d    = 1'b0;
        end else if (error_flag && state_q != IDLE && snap_valid_q) begin
            // Retract: only one level of history, so a second retract is a no-op.
            state_d      = CONVERT;
            q_d          = snap_q_q;
            qm_d         = snap_qm_q;
            snap_valid_d = 1'b0;
            count_d      = count_q - CW'(1);
        end else if (accept) begin
            snap_q_d     = q_q;
            snap_qm_d    = qm_q;
            snap_valid_d = 1'b1;
            q_d          = step_q;
            qm_d         = step_qm;
            count_d      = count_q + CW'(1);
            invalid_d    = invalid_q | step_illegal;
            if (count_d == CW'(N_DIGITS)) state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            q_q          <= '0;
            qm_q         <= '1;
            snap_q_q     <= '0;
            snap_qm_q    <= '1;
            snap_valid_q <= 1'b0;
            count_q      <= '0;
            invalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            qm_q         <= qm_d;
            snap_q_q     <= snap_q_d;
            snap_qm_q    <= snap_qm_d;
            snap_valid_q <= snap_valid_d;
            count_q      <= count_d;
            invalid_q    <= invalid_d;
        end
    end

endmodule

// File: tb/tb_otf_quotient_converter.sv
// Directed self-checking bench for otf_quotient_converter at N_DIGITS=4.
module tb_otf_quotient_converter;

    localparam int N  = 4;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           digit_valid = 1'b0;
    logic [1:0]     q_value = 2'b00;
    logic           error_flag = 1'b0;
    logic           digit_ready;
    logic [N:0]     quotient;
    logic [CW-1:0]  digit_count;
    logic           done;
    logic           invalid_digit;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] P = 2'b01, Z = 2'b00, M = 2'b11, X = 2'b10;

    otf_quotient_converter #(.N_DIGITS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .digit_valid   (digit_valid),
        .q_value       (q_value),
        .error_flag    (error_flag),
        .digit_ready   (digit_ready),
        .quotient      (quotient),
        .digit_count   (digit_count),
        .done          (done),
        .invalid_digit (invalid_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic s, input logic dv, input logic [1:0] qv, input logic err);
        start       = s;
        digit_valid = dv;
        q_value     = qv;
        error_flag  = err;
        @(posedge clk);
        #1;
        start       = 1'b0;
        digit_valid = 1'b0;
        q_value     = 2'b00;
        error_flag  = 1'b0;
    endtask

    task automatic digit(input logic [1:0] qv);
        cyc(1'b0, 1'b1, qv, 1'b0);
    endtask

    task automatic expect_state(input string tag, input int q, input int cnt, input logic dn, input logic rdy);
        check({tag, "_q"},     32'(quotient),    32'(q[N:0]));
        check({tag, "_cnt"},   32'(digit_count), 32'(cnt));
        check({tag, "_done"},  32'(done),        32'(dn));
        check({tag, "_ready"}, 32'(digit_ready), 32'(rdy));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset", 0, 0, 1'b0, 1'b0);
        check("reset_inv", 32'(invalid_digit), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // IDLE ignores digits and retracts
        digit(P);
        cyc(1'b0, 1'b0, Z, 1'b1);
        expect_state("idle", 0, 0, 1'b0, 1'b0);

        // +1,0,-1,+1 -> 7
        cyc(1'b1, 1'b0, Z, 1'b0);
        expect_state("start1", 0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, Z, 1'b1);
        expect_state("err_cnt0", 0, 0, 1'b0, 1'b1);
        digit(P); expect_state("a_d1", 1, 1, 1'b0, 1'b1);
        digit(Z); expect_state("a_d2", 2, 2, 1'b0, 1'b1);
        digit(M); expect_state("a_d3", 3, 3, 1'b0, 1'b1);
        digit(P); expect_state("a_d4", 7, 4, 1'b1, 1'b0);
        digit(P); expect_state("a_hold", 7, 4, 1'b1, 1'b0);

        // retract from DONE, then re-complete
        cyc(1'b0, 1'b0, Z, 1'b1);
        expect_state("done_err", 3, 3, 1'b0, 1'b1);
        digit(P); expect_state("recomplete", 7, 4, 1'b1, 1'b0);

        // -1 x4 -> -15 (5'b10001)
        cyc(1'b1, 1'b0, Z, 1'b0);
        digit(M); expect_state("b_d1", 5'b11111, 1, 1'b0, 1'b1);
        digit(M); digit(M);
        digit(M); expect_state("b_d4", 5'b10001, 4, 1'b1, 1'b0);

        // +1,+1, retract, retract (ignored), -1,0,+1 -> 5
        cyc(1'b1, 1'b0, Z, 1'b0);
        digit(P); expect_state("c_d1", 1, 1, 1'b0, 1'b1);
        digit(P); expect_state("c_d2", 3, 2, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, P, 1'b1);
        expect_state("c_err1", 1, 1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, Z, 1'b1);
        expect_state("c_err2", 1, 1, 1'b0, 1'b1);
        digit(M); expect_state("c_d3", 1, 2, 1'b0, 1'b1);
        digit(Z); expect_state("c_d4", 2, 3, 1'b0, 1'b1);
        digit(P); expect_state("c_d5", 5, 4, 1'b1, 1'b0);

        // start overrides a same-cycle digit; illegal digit converts as 0 and is sticky
        cyc(1'b1, 1'b1, P, 1'b0);
        expect_state("d_start", 0, 0, 1'b0, 1'b1);
        digit(X);
        expect_state("d_ill", 0, 1, 1'b0, 1'b1);
        check("d_inv1", 32'(invalid_digit), 32'd1);
        digit(P);
        expect_state("d_after", 1, 2, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, Z, 1'b1);
        check("d_inv_retract", 32'(invalid_digit), 32'd1);
        cyc(1'b1, 1'b0, Z, 1'b0);
        check("d_inv_clr", 32'(invalid_digit), 32'd0);

        // async reset mid-conversion
        digit(P); digit(P);
        expect_state("e_pre", 3, 2, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 expect_state("e_rst", 0, 0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        digit(P);
        expect_state("e_ignored", 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, Z, 1'b0);
        digit(M);
        expect_state("e_restart", 5'b11111, 1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
